simd_ctrl_pipe: RTL and testbench
=================================

SIMD_CTRL_PIPE -- requirements
Module: simd_ctrl_pipe

Interface
REQ-001 LANES, default 4, vector lane count; power of 2, range 2..16.
REQ-002 MEMPORTS, default 1, lanes per memory beat; power of 2 dividing LANES; BEATS=LANES/MEMPORTS; IW=max(1,clog2(LANES)).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Type  in  3  D-stage class: 000 ALU-reg, 001 ALU-imm, 010 LDR, 011 STR, 100 VALU, 101 VLDR, 110 VSTR, 111 NOP.
REQ-006 Op  in  4  D-stage ALU opcode.
REQ-007 Cond  in  4  D-stage condition field.
REQ-008 ALUFlagsE  in  4  {N,Z,C,V} from E stage.
REQ-009 FlushE  in  1  clears E register at next edge.
REQ-010 RegSrcD  out  2  register-read select, combinational.
REQ-011 ImmSrcD  out  2  immediate format, combinational.
REQ-012 ALUSrcE  out  1  immediate operand select.
REQ-013 ALUControlE  out  4  ALU operation.
REQ-014 VecE  out  1  E-stage op is vector.
REQ-015 MemWriteGatedE  out  1  condition-gated memory write strobe.
REQ-016 MemtoRegE  out  1  load in E, for hazard unit.
REQ-017 RegWriteM  out  1  register write pending in M.
REQ-018 MemtoRegW  out  1  writeback from memory.
REQ-019 RegWriteW  out  1  gated register write.
REQ-020 LaneIdxM  out  IW  first lane of current M-stage beat.
REQ-021 LaneIdxW  out  IW  first lane of current W-stage beat.
REQ-022 BusyD  out  1  stall request to F/D, registered.

Function
REQ-023 Decode: RegSrcD=10 for 011/110, else 00; ImmSrcD=01 for 010/011/101/110, else 00; ALUSrc=1 for 001,010,011,101,110.
REQ-024 ALUControl=Op for 000/001/100, 0000 (add) for memory types; RegWrite for 000,001,010,100,101; MemtoReg for 010/101; MemWrite for 011/110; 111 sets all strobes 0.
REQ-025 D->E, E->M, M->W control registers update every edge; latency D decode to W outputs: 3 cycles.
REQ-026 FSM states IDLE, SEQ; IDLE->SEQ when E holds VLDR/VSTR, not flushed, condition passes, BEATS>1.
REQ-027 In SEQ the E register holds, beat counter increments 0..BEATS-1, each cycle emits one beat to M with LaneIdxM=beat*MEMPORTS; SEQ->IDLE after beat BEATS-1.
REQ-028 BusyD=1 from the edge entering SEQ until the edge leaving it (BEATS-1 cycles); D register holds while BusyD=1.
REQ-029 Each VSTR beat asserts MemWriteGatedE; each VLDR beat asserts RegWriteW at W with matching LaneIdxW.
REQ-030 Scalar and VALU ops: one beat, LaneIdx=0.
REQ-031 FlushE in IDLE or SEQ: E cleared to NOP, FSM->IDLE, counter->0 at that edge; beats already in M/W complete.
REQ-032 Condition-failed op: RegWrite/MemWrite gated 0, no SEQ entry, flows as bubble.

Reset
REQ-033 reset=0 asynchronously clears all pipeline registers, FSM->IDLE, counter 0; all E/M/W outputs and BusyD read 0.
REQ-034 Reset mid-SEQ aborts the sequence; no further beats after release.

Configuration
REQ-035 SIMDCTRL_COND_EN defined: Cond evaluated in E vs ALUFlagsE: 0000 EQ(Z), 0001 NE(!Z), 1010 GE(N==V), 1011 LT(N!=V), other codes always.
REQ-036 SIMDCTRL_COND_EN undefined: Cond port present but ignored; every op passes.

Verification
REQ-037 Type=000, Op=0010 -> 3 cycles later RegWriteW=1, MemtoRegW=0; ALUControlE=0010 one cycle after decode.
REQ-038 LANES=4, MEMPORTS=1, Type=101 -> BusyD=1 for 3 cycles, LaneIdxW 0,1,2,3 with RegWriteW=1, MemtoRegW=1 each.
REQ-039 Type=110, FlushE=1 on second beat -> exactly 2 MemWriteGatedE pulses, BusyD=0 next cycle.
REQ-040 COND_EN, Cond=0000, ALUFlagsE=0000, Type=110 -> MemWriteGatedE=0, BusyD stays 0.
REQ-041 reset=0 during SEQ beat 1 -> all outputs 0 immediately; no beats after release.
REQ-042 LANES=8, MEMPORTS=2, Type=101 -> 4 beats, LaneIdxM 0,2,4,6.

Source files
------------

// File: rtl/simd_ctrl_pipe.sv
// D/E/M/W control pipeline for a SIMD core with a multi-beat vector load/store sequencer in E.
// Optional macro SIMDCTRL_COND_EN enables condition-code gating in E; otherwise every op passes.
module simd_ctrl_pipe #(
    parameter  int LANES    = 4,
    parameter  int MEMPORTS = 1,
    localparam int BEATS    = LANES / MEMPORTS,
    localparam int IW       = (LANES > 2) ? $clog2(LANES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    Type,
    input  logic [3:0]    Op,
    input  logic [3:0]    Cond,
    input  logic [3:0]    ALUFlagsE,
    input  logic          FlushE,
    output logic [1:0]    RegSrcD,
    output logic [1:0]    ImmSrcD,
    output logic          ALUSrcE,
    output logic [3:0]    ALUControlE,
    output logic          VecE,
    output logic          MemWriteGatedE,
    output logic          MemtoRegE,
    output logic          RegWriteM,
    output logic          MemtoRegW,
    output logic          RegWriteW,
    output logic [IW-1:0] LaneIdxM,
    output logic [IW-1:0] LaneIdxW,
    output logic          BusyD
);
    localparam int BW = (BEATS > 2) ? $clog2(BEATS) : 1;

    typedef struct packed {
        logic       alusrc;
        logic [3:0] aluctrl;
        logic       regw;
        logic       memtoreg;
        logic       memw;
        logic       vec;
        logic       vmem;
        logic [3:0] cond;
    } ectl_t;

    typedef struct packed {
        logic          regw;
        logic          memtoreg;
        logic [IW-1:0] lane;
    } beat_t;

    typedef enum logic {IDLE, SEQ} state_t;

    ectl_t   ctl_d, e_q;
    beat_t   m_q, w_q;
    state_t  state_q;
    logic [BW-1:0] cnt_q;
    logic    busy_q;
    logic    cond_ok, beat_pass, last_beat, multi_ok, hold_e;
    logic [IW-1:0] lane_e;

    always_comb begin
        ctl_d      = '0;
        ctl_d.cond = Cond;
        RegSrcD    = 2'b00;
        ImmSrcD    = 2'b00;
        case (Type)
            3'b000: begin ctl_d.aluctrl = Op; ctl_d.regw = 1'b1; end
            3'b001: begin ctl_d.aluctrl = Op; ctl_d.regw = 1'b1; ctl_d.alusrc = 1'b1; end
            3'b010: begin
                ctl_d.alusrc = 1'b1; ctl_d.regw = 1'b1; ctl_d.memtoreg = 1'b1;
                ImmSrcD = 2'b01;
            end
            3'b011: begin
                ctl_d.alusrc = 1'b1; ctl_d.memw = 1'b1;
                RegSrcD = 2'b10; ImmSrcD = 2'b01;
            end
            3'b100: begin ctl_d.aluctrl = Op; ctl_d.regw = 1'b1; ctl_d.vec = 1'b1; end
            3'b101: begin
                ctl_d.alusrc = 1'b1; ctl_d.regw = 1'b1; ctl_d.memtoreg = 1'b1;
                ctl_d.vec = 1'b1; ctl_d.vmem = 1'b1;
                ImmSrcD = 2'b01;
            end
            3'b110: begin
                ctl_d.alusrc = 1'b1; ctl_d.memw = 1'b1;
                ctl_d.vec = 1'b1; ctl_d.vmem = 1'b1;
                RegSrcD = 2'b10; ImmSrcD = 2'b01;
            end
            default: ;
        endcase
    end

`ifdef SIMDCTRL_COND_EN
    always_comb begin
        case (e_q.cond)
            4'b0000: cond_ok = ALUFlagsE[2];
            4'b0001: cond_ok = ~ALUFlagsE[2];
            4'b1010: cond_ok = (ALUFlagsE[3] == ALUFlagsE[0]);
            4'b1011: cond_ok = (ALUFlagsE[3] != ALUFlagsE[0]);
            default: cond_ok = 1'b1;
        endcase
    end
    logic unused_carry;
    assign unused_carry = ALUFlagsE[1];
`else
    assign cond_ok = 1'b1;
    logic unused_cond;
    assign unused_cond = ^{e_q.cond, ALUFlagsE};
`endif

    // The condition is judged once on beat 0; later beats inherit that verdict even if flags move.
    assign beat_pass = (state_q == SEQ) | cond_ok;
    assign last_beat = (cnt_q == BW'(BEATS - 1));
    assign multi_ok  = (BEATS > 1) && e_q.vmem && beat_pass;
    assign hold_e    = multi_ok & ~last_beat & ~FlushE;
    assign lane_e    = IW'(cnt_q) * IW'(MEMPORTS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       e_q <= '0;
        else if (FlushE)  e_q <= '0;
        else if (!hold_e) e_q <= ctl_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (FlushE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (multi_ok) begin
                    state_q <= SEQ;
                    cnt_q   <= BW'(1);
                    busy_q  <= 1'b1;
                end
                SEQ: if (last_beat) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_q + BW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // M and W keep flowing under FlushE so beats already issued still retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q.regw     <= e_q.regw & beat_pass;
            m_q.memtoreg <= e_q.memtoreg;
            m_q.lane     <= lane_e;
            w_q          <= m_q;
        end
    end

    assign ALUSrcE        = e_q.alusrc;
    assign ALUControlE    = e_q.aluctrl;
    assign VecE           = e_q.vec;
    assign MemtoRegE      = e_q.memtoreg;
    assign MemWriteGatedE = e_q.memw & beat_pass;
    assign RegWriteM      = m_q.regw;
    assign LaneIdxM       = m_q.lane;
    assign MemtoRegW      = w_q.memtoreg;
    assign RegWriteW      = w_q.regw;
    assign LaneIdxW       = w_q.lane;
    assign BusyD          = busy_q;
endmodule

// File: tb/tb_simd_ctrl_pipe.sv
// Bench for simd_ctrl_pipe: two instances (4x1 and 8x2) against a beat-level model plus directed cases.
module tb_simd_ctrl_pipe;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] Type = 3'd7;
    logic [3:0] Op = '0, Cond = 4'hE, ALUFlagsE = '0;
    logic FlushE = 1'b0;

    logic [1:0] a_RegSrcD, a_ImmSrcD, b_RegSrcD, b_ImmSrcD;
    logic a_ALUSrcE, a_VecE, a_MWE, a_MtrE, a_RWM, a_MtrW, a_RWW, a_Busy;
    logic b_ALUSrcE, b_VecE, b_MWE, b_MtrE, b_RWM, b_MtrW, b_RWW, b_Busy;
    logic [3:0] a_ALUCtl, b_ALUCtl;
    logic [1:0] a_LIM, a_LIW;
    logic [2:0] b_LIM, b_LIW;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simd_ctrl_pipe #(.LANES(4), .MEMPORTS(1)) u_a (
        .clk(clk), .reset(reset), .Type(Type), .Op(Op), .Cond(Cond), .ALUFlagsE(ALUFlagsE),
        .FlushE(FlushE), .RegSrcD(a_RegSrcD), .ImmSrcD(a_ImmSrcD), .ALUSrcE(a_ALUSrcE),
        .ALUControlE(a_ALUCtl), .VecE(a_VecE), .MemWriteGatedE(a_MWE), .MemtoRegE(a_MtrE),
        .RegWriteM(a_RWM), .MemtoRegW(a_MtrW), .RegWriteW(a_RWW), .LaneIdxM(a_LIM),
        .LaneIdxW(a_LIW), .BusyD(a_Busy));

    simd_ctrl_pipe #(.LANES(8), .MEMPORTS(2)) u_b (
        .clk(clk), .reset(reset), .Type(Type), .Op(Op), .Cond(Cond), .ALUFlagsE(ALUFlagsE),
        .FlushE(FlushE), .RegSrcD(b_RegSrcD), .ImmSrcD(b_ImmSrcD), .ALUSrcE(b_ALUSrcE),
        .ALUControlE(b_ALUCtl), .VecE(b_VecE), .MemWriteGatedE(b_MWE), .MemtoRegE(b_MtrE),
        .RegWriteM(b_RWM), .MemtoRegW(b_MtrW), .RegWriteW(b_RWW), .LaneIdxM(b_LIM),
        .LaneIdxW(b_LIW), .BusyD(b_Busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_ok(int c, logic [3:0] f);
        bit r;
        case (c)
            0:  r = f[2];
            1:  r = !f[2];
            10: r = (f[3] == f[0]);
            11: r = (f[3] != f[0]);
            default: r = 1'b1;
        endcase
`ifndef SIMDCTRL_COND_EN
        r = 1'b1;
`endif
        return r;
    endfunction

    // Model: the instruction sitting in E, which beat of it is current, and the beats in M and W.
    int m_typ = 7, m_op = 0, m_cond = 0, m_k = 0;
    bit mb_regw = 0, mb_mtr = 0, w_regw = 0, w_mtr = 0;
    int mb_k = 0, w_k = 0;
    logic p_now;
    assign p_now = (m_k > 0) || cond_ok(m_cond, ALUFlagsE);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_typ <= 7; m_op <= 0; m_cond <= 0; m_k <= 0;
            mb_regw <= 0; mb_mtr <= 0; mb_k <= 0;
            w_regw <= 0; w_mtr <= 0; w_k <= 0;
        end else begin
            w_regw  <= mb_regw;
            w_mtr   <= mb_mtr;
            w_k     <= mb_k;
            mb_regw <= (m_typ inside {0, 1, 2, 4, 5}) && p_now;
            mb_mtr  <= (m_typ inside {2, 5});
            mb_k    <= m_k;
            if (FlushE) begin
                m_typ <= 7; m_k <= 0;
            end else if ((m_typ inside {5, 6}) && p_now && (m_k < BEATS - 1)) begin
                m_k <= m_k + 1;
            end else begin
                m_typ <= int'(Type); m_op <= int'(Op); m_cond <= int'(Cond); m_k <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("RegSrcD", a_RegSrcD, (Type inside {3, 6}) ? 2 : 0);
        chk("ImmSrcD", a_ImmSrcD, (Type inside {2, 3, 5, 6}) ? 1 : 0);
        chk("ALUSrcE", a_ALUSrcE, (m_typ inside {1, 2, 3, 5, 6}) ? 1 : 0);
        chk("ALUControlE", a_ALUCtl, (m_typ inside {0, 1, 4}) ? m_op : 0);
        chk("VecE", a_VecE, (m_typ inside {4, 5, 6}) ? 1 : 0);
        chk("MemtoRegE", a_MtrE, (m_typ inside {2, 5}) ? 1 : 0);
        chk("MemWriteGatedE", a_MWE, ((m_typ inside {3, 6}) && p_now) ? 1 : 0);
        chk("BusyD", a_Busy, (m_k != 0) ? 1 : 0);
        chk("RegWriteM", a_RWM, mb_regw);
        chk("LaneIdxM", a_LIM, mb_k);
        chk("MemtoRegW", a_MtrW, w_mtr);
        chk("RegWriteW", a_RWW, w_regw);
        chk("LaneIdxW", a_LIW, w_k);
        chk("b_MemWriteGatedE", b_MWE, ((m_typ inside {3, 6}) && p_now) ? 1 : 0);
        chk("b_BusyD", b_Busy, (m_k != 0) ? 1 : 0);
        chk("b_RegWriteM", b_RWM, mb_regw);
        chk("b_LaneIdxM", b_LIM, mb_k * 2);
        chk("b_RegWriteW", b_RWW, w_regw);
        chk("b_MemtoRegW", b_MtrW, w_mtr);
        chk("b_LaneIdxW", b_LIW, w_k * 2);
        chk("b_ALUControlE", b_ALUCtl, (m_typ inside {0, 1, 4}) ? m_op : 0);
    end

    initial begin
        int busy, pulses, bad;
        int lw[$];
        int lm[$];

        #1 reset = 1'b0;
        #1;
        chk("rst_BusyD", a_Busy, 0);
        chk("rst_RegWriteW", a_RWW, 0);
        chk("rst_ALUControlE", a_ALUCtl, 0);
        chk("rst_MemWriteGatedE", a_MWE, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        step(); step();

        // Scalar ALU-reg op: ALUControl visible in E, write retires at W three cycles after decode.
        Type = 3'd0; Op = 4'b0010;
        step();
        Type = 3'd7;
        chk("d37_ALUControlE", a_ALUCtl, 4'b0010);
        step(); step();
        chk("d37_RegWriteW", a_RWW, 1);
        chk("d37_MemtoRegW", a_MtrW, 0);
        step(); step(); step();

        // VLDR: three busy cycles; 4x1 retires lanes 0..3, 8x2 issues lanes 0,2,4,6.
        Type = 3'd5;
        step();
        Type = 3'd7;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_Busy) busy++;
            if (a_RWW && a_MtrW) lw.push_back(int'(a_LIW));
            if (b_RWM) lm.push_back(int'(b_LIM));
            step();
        end
        chk("d38_busy_cycles", busy, 3);
        chk("d38_w_beats", lw.size(), 4);
        chk("d42_m_beats", lm.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("d38_LaneIdxW", (lw.size() > i) ? lw[i] : -1, i);
            chk("d42_LaneIdxM", (lm.size() > i) ? lm[i] : -1, 2 * i);
        end

        // VSTR flushed on its second beat: two write strobes, busy drops right after.
        Type = 3'd6;
        step();
        Type = 3'd7;
        pulses = 0;
        if (a_MWE) pulses++;
        step();
        if (a_MWE) pulses++;
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        chk("d39_BusyD_after_flush", a_Busy, 0);
        chk("d39_b_BusyD_after_flush", b_Busy, 0);
        for (int i = 0; i < 4; i++) begin
            if (a_MWE) pulses++;
            step();
        end
        chk("d39_write_pulses", pulses, 2);

`ifdef SIMDCTRL_COND_EN
        // EQ with Z clear: the store is suppressed and never sequences.
        ALUFlagsE = 4'b0000; Cond = 4'b0000; Type = 3'd6;
        step();
        Type = 3'd7; Cond = 4'hE;
        pulses = 0; busy = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_MWE) pulses++;
            if (a_Busy) busy++;
            step();
        end
        chk("d40_write_pulses", pulses, 0);
        chk("d40_busy_cycles", busy, 0);
`endif

        // Reset in the middle of a VLDR sequence.
        Type = 3'd5;
        step();
        Type = 3'd7;
        step();
        chk("d41_BusyD_in_seq", a_Busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("d41_BusyD", a_Busy, 0);
        chk("d41_RegWriteM", a_RWM, 0);
        chk("d41_RegWriteW", a_RWW, 0);
        chk("d41_MtrE", a_MtrE, 0);
        chk("d41_VecE", a_VecE, 0);
        chk("d41_b_LaneIdxM", b_LIM, 0);
        chk("d41_b_BusyD", b_Busy, 0);
        step(); step();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_RWM || a_RWW || a_Busy || a_MWE || b_RWM || b_RWW) bad++;
            step();
        end
        chk("d41_beats_after_release", bad, 0);

        // Randomized traffic, biased toward vector memory ops, with flushes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 4) Type = $urandom_range(0, 1) ? 3'd5 : 3'd6;
            else Type = 3'($urandom_range(0, 7));
            Op        = 4'($urandom);
            Cond      = $urandom_range(0, 1) ? 4'hE : 4'($urandom);
            ALUFlagsE = 4'($urandom);
            FlushE    = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1'b1; FlushE = 1'b0; Type = 3'd7;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
